sym_err_meas: RTL and testbench
===============================

Name: sym_err_meas

Overview:
- Parametrised, multi-channel symbol-error-rate measurement block for the MER test bench.
- Feeds each channel's LFSR reference symbol through a runtime-selectable delay line and compares it with that channel's slicer decision on every symbol enable.
- Accumulates per-channel symbol errors over a measurement window bounded by the LFSR cycle pulse, then latches the results for SignalTap/ISSP readout.
- Replaces the fixed 3-deep I/Q compare logic and generalises it to NUM_CH channels with a window state machine.

Parameters:
- NUM_CH, 2, number of independent channels (I, Q, ...).
- SYM_W, 2, bits per reference/decision symbol.
- MAX_DELAY, 8, depth of each reference delay line in symbols.
- DLY_W, 3, width of delay_sel; 2**DLY_W >= MAX_DELAY.
- CNT_W, 22, width of the error and symbol counters.

Ports:
- sys_clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- sym_clk_en  in  1  one-cycle symbol enable.
- clr_acc  in  1  window boundary pulse (LFSR cycle); qualified only when sym_clk_en=1.
- ref_sym  in  NUM_CH*SYM_W  packed LFSR reference symbols; channel c occupies [c*SYM_W +: SYM_W].
- slice  in  NUM_CH*SYM_W  packed slicer decisions, same packing as ref_sym.
- delay_sel  in  DLY_W  reference delay minus 1; compare delay = delay_sel+1 symbols.
- start  in  1  one-shot measurement request.
- cont_mode  in  1  1 = back-to-back windows without start.
- sym_err  out  NUM_CH  registered per-symbol mismatch flags.
- err_cnt  out  NUM_CH*CNT_W  latched per-channel error counts of the last window.
- sym_cnt  out  CNT_W  latched symbol count of the last window.
- overflow  out  1  latched: a counter saturated in the last window.
- result_valid  out  1  one-cycle pulse when results update.
- busy  out  1  high in ARM or MEASURE.

Behaviour:
- Reset (reset=0, async): all delay taps, counters, outputs and state clear to 0; state=IDLE.
- Delay line:
  - Per channel, shifts on sym_clk_en only.
  - Tap k holds ref_sym captured k+1 enables ago.
  - Compare tap = delay_sel. delay_sel >= MAX_DELAY clamps to MAX_DELAY-1.
  - delay_sel=2 reproduces the legacy 3-symbol alignment.
- Compare: on sym_clk_en, sym_err[c] <= (tap[c] != slice[c]). sym_err holds between enables; latency 1 sys_clk after the enable.
- State machine:
  - IDLE: busy=0. Goes to ARM on start=1 or cont_mode=1.
  - ARM: waits for sym_clk_en & clr_acc. Then clears working counters and goes to MEASURE; the boundary symbol is not counted.
  - MEASURE: on each sym_clk_en without clr_acc, working sym counter +1 and each working err counter +mismatch[c].
  - Window close, MEASURE with sym_clk_en & clr_acc:
    - The boundary symbol is counted into the closing window.
    - Totals are latched to err_cnt/sym_cnt/overflow.
    - result_valid=1 on the following cycle.
    - Working counters and working overflow clear.
    - Next state is MEASURE if cont_mode=1, else IDLE.
- Saturation: working counters stop at 2**CNT_W-1 and the working overflow flag sets; this flag is sticky within the window.
- Delay change: if delay_sel changes during ARM or MEASURE, discard the working window, clear working counters and return to ARM. The latched outputs keep their previous values.
- Ignored events: start during ARM/MEASURE is ignored. clr_acc without sym_clk_en is ignored everywhere.
- Mode change: cont_mode dropping mid-window lets the current window finish, then goes to IDLE.
- Latched outputs change only at window close or reset.

Test Plan:
- Slice = reference delayed 3 symbols, delay_sel=2, one window of 100 symbols -> err_cnt=0 for all channels, sym_cnt=100, overflow=0, one result_valid pulse.
- Same stimulus with delay_sel=1 on random 2-bit symbols -> err_cnt near 75 per 100 symbols; sym_err toggles 1 cycle after each sym_clk_en.
- Channel 1 slice forced to complement of its tap for 10 symbols inside a 50-symbol window -> err_cnt[1]=10, err_cnt[0]=0, sym_cnt=50.
- CNT_W=4 with a 20-symbol all-error window -> err_cnt=15, sym_cnt=15, overflow=1; next window with no errors -> overflow=0.
- cont_mode=1 with clr_acc every 64 symbols -> result_valid every 64 enables and sym_cnt=64 each time. delay_sel changed mid-window -> no pulse for that window, re-arms at the next clr_acc.
- reset asserted mid-MEASURE -> all outputs 0 immediately and state=IDLE; start afterwards re-arms normally.

Source files
------------

// File: rtl/sym_err_meas.sv
// rtl/sym_err_meas.sv - multi-channel symbol error counter with delayed-reference compare and window FSM
module sym_err_meas #(
    parameter int NUM_CH    = 2,
    parameter int SYM_W     = 2,
    parameter int MAX_DELAY = 8,
    parameter int DLY_W     = 3,
    parameter int CNT_W     = 22
) (
    input  logic                      sys_clk,
    input  logic                      reset,
    input  logic                      sym_clk_en,
    input  logic                      clr_acc,
    input  logic [NUM_CH*SYM_W-1:0]   ref_sym,
    input  logic [NUM_CH*SYM_W-1:0]   slice,
    input  logic [DLY_W-1:0]          delay_sel,
    input  logic                      start,
    input  logic                      cont_mode,
    output logic [NUM_CH-1:0]         sym_err,
    output logic [NUM_CH*CNT_W-1:0]   err_cnt,
    output logic [CNT_W-1:0]          sym_cnt,
    output logic                      overflow,
    output logic                      result_valid,
    output logic                      busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [DLY_W:0]   MAXD     = (DLY_W+1)'(MAX_DELAY);
    localparam logic [DLY_W-1:0] LAST_TAP = DLY_W'(MAX_DELAY - 1);

    state_t             state_q, state_d;
    logic [SYM_W-1:0]   tap_q [NUM_CH][MAX_DELAY];
    logic [DLY_W-1:0]   sel_eff;
    logic [DLY_W-1:0]   dly_q;
    logic               dly_chg;
    logic               sym_bnd;
    logic [NUM_CH-1:0]  mismatch;
    logic [NUM_CH-1:0]  sym_err_q;

    logic [CNT_W-1:0]   werr_q [NUM_CH];
    logic [CNT_W-1:0]   err_nxt [NUM_CH];
    logic [CNT_W-1:0]   wsym_q, sym_nxt;
    logic               wovf_q, ovf_nxt, err_sat_any;

    logic [NUM_CH*CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0]        sym_cnt_q;
    logic                    ovf_q, rv_q;

    logic               arm_go, close_evt, count_evt, clr_work;

    assign sel_eff = ({1'b0, delay_sel} >= MAXD) ? LAST_TAP : delay_sel;
    assign dly_chg = (delay_sel != dly_q);
    assign sym_bnd = sym_clk_en & clr_acc;

    // Tap k holds the reference captured k+1 enables ago
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < MAX_DELAY; k++)
                    tap_q[c][k] <= '0;
            sym_err_q <= '0;
            dly_q     <= '0;
        end else begin
            dly_q <= delay_sel;
            if (sym_clk_en) begin
                sym_err_q <= mismatch;
                for (int c = 0; c < NUM_CH; c++) begin
                    tap_q[c][0] <= ref_sym[c*SYM_W +: SYM_W];
                    for (int k = 1; k < MAX_DELAY; k++)
                        tap_q[c][k] <= tap_q[c][k-1];
                end
            end
        end
    end

    always_comb begin
        err_sat_any = 1'b0;
        mismatch    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mismatch[c] = (tap_q[c][sel_eff] != slice[c*SYM_W +: SYM_W]);
            if (mismatch[c] && (werr_q[c] == CNT_MAX))
                err_sat_any = 1'b1;
            err_nxt[c] = (mismatch[c] && (werr_q[c] != CNT_MAX)) ? werr_q[c] + CNT_W'(1) : werr_q[c];
        end
        sym_nxt = (wsym_q != CNT_MAX) ? wsym_q + CNT_W'(1) : wsym_q;
        ovf_nxt = wovf_q | err_sat_any | (wsym_q == CNT_MAX);
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start || cont_mode) state_d = ST_ARM;
            ST_ARM:  if (!dly_chg && sym_bnd) state_d = ST_MEAS;
            ST_MEAS: begin
                if (dly_chg)      state_d = ST_ARM;
                else if (sym_bnd) state_d = cont_mode ? ST_MEAS : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != ST_IDLE);
        arm_go    = (state_q == ST_ARM)  && !dly_chg && sym_bnd;
        close_evt = (state_q == ST_MEAS) && !dly_chg && sym_bnd;
        count_evt = (state_q == ST_MEAS) && !dly_chg && sym_clk_en && !clr_acc;
        clr_work  = arm_go || close_evt || (busy && dly_chg);
    end

    // Closing boundary symbol is folded into the latched totals
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) werr_q[c] <= '0;
            wsym_q    <= '0;
            wovf_q    <= 1'b0;
            err_cnt_q <= '0;
            sym_cnt_q <= '0;
            ovf_q     <= 1'b0;
            rv_q      <= 1'b0;
        end else begin
            rv_q <= close_evt;
            if (clr_work) begin
                for (int c = 0; c < NUM_CH; c++) werr_q[c] <= '0;
                wsym_q <= '0;
                wovf_q <= 1'b0;
            end else if (count_evt) begin
                for (int c = 0; c < NUM_CH; c++) werr_q[c] <= err_nxt[c];
                wsym_q <= sym_nxt;
                wovf_q <= ovf_nxt;
            end
            if (close_evt) begin
                for (int c = 0; c < NUM_CH; c++) err_cnt_q[c*CNT_W +: CNT_W] <= err_nxt[c];
                sym_cnt_q <= sym_nxt;
                ovf_q     <= ovf_nxt;
            end
        end
    end

    assign sym_err      = sym_err_q;
    assign err_cnt      = err_cnt_q;
    assign sym_cnt      = sym_cnt_q;
    assign overflow     = ovf_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_sym_err_meas.sv
// tb/tb_sym_err_meas.sv - directed self-checking bench for sym_err_meas
module tb_sym_err_meas;

    logic        clk = 1'b0;
    logic        rst_n, en, clr, start, cont;
    logic [3:0]  ref_sym, slice;
    logic [2:0]  dsel;

    logic [1:0]  sym_err, sym_err_s;
    logic [43:0] err_cnt;
    logic [7:0]  err_cnt_s;
    logic [21:0] sym_cnt;
    logic [3:0]  sym_cnt_s;
    logic        ovf, ovf_s, rv, rv_s, busy, busy_s;

    int          n_tests = 0, n_fail = 0;
    int          rv_cnt = 0, rv_base;
    int          e0, e1;
    logic        model_on;
    logic [3:0]  hist [8];
    logic [2:0]  slc_dly;
    logic [3:0]  last_m;

    always #5 clk = ~clk;

    sym_err_meas dut (
        .sys_clk(clk), .reset(rst_n), .sym_clk_en(en), .clr_acc(clr),
        .ref_sym(ref_sym), .slice(slice), .delay_sel(dsel), .start(start),
        .cont_mode(cont), .sym_err(sym_err), .err_cnt(err_cnt), .sym_cnt(sym_cnt),
        .overflow(ovf), .result_valid(rv), .busy(busy)
    );

    sym_err_meas #(.CNT_W(4)) dut_s (
        .sys_clk(clk), .reset(rst_n), .sym_clk_en(en), .clr_acc(clr),
        .ref_sym(ref_sym), .slice(slice), .delay_sel(dsel), .start(start),
        .cont_mode(cont), .sym_err(sym_err_s), .err_cnt(err_cnt_s), .sym_cnt(sym_cnt_s),
        .overflow(ovf_s), .result_valid(rv_s), .busy(busy_s)
    );

    always @(negedge clk) if (rv === 1'b1) rv_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Slice follows the reference slc_dly+1 symbols back, optionally corrupted by err_mask
    task automatic send(input logic clr_in, input logic [3:0] err_mask);
        logic [3:0] r, s, m;
        r = 4'($urandom_range(0, 15));
        s = hist[slc_dly] ^ err_mask;
        m = hist[dsel] ^ s;
        @(negedge clk);
        ref_sym = r; slice = s; clr = clr_in; en = 1'b1;
        if (model_on) begin
            e0 += (m[1:0] != 2'b00) ? 1 : 0;
            e1 += (m[3:2] != 2'b00) ? 1 : 0;
        end
        last_m = m;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = r;
        @(negedge clk);
        en = 1'b0; clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic clear_hist();
        for (int k = 0; k < 8; k++) hist[k] = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0; en = 0; clr = 0; start = 0; cont = 0;
        ref_sym = 0; slice = 0; dsel = 3'd2; slc_dly = 3'd2;
        model_on = 0; e0 = 0; e1 = 0; last_m = 0;
        clear_hist();
        #22;
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_sym_cnt", 32'(sym_cnt), 0);
        check("rst_flags", {ovf, rv, busy, sym_err}, 0);
        @(negedge clk); rst_n = 1'b1;
        idle(2);

        // Aligned window of 100 symbols, with ignored clr/start glitches inside
        pulse_start();
        check("t1_busy_arm", 32'(busy), 1);
        repeat (5) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        rv_base = rv_cnt;
        repeat (50) send(1'b0, 4'h0);
        @(negedge clk); clr = 1'b1; start = 1'b1;
        @(negedge clk); clr = 1'b0; start = 1'b0;
        check("t1_no_early_pulse", 32'(rv_cnt - rv_base), 0);
        repeat (49) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(2);
        check("t1_err0", 32'(err_cnt[21:0]), 0);
        check("t1_err1", 32'(err_cnt[43:22]), 0);
        check("t1_sym_cnt", 32'(sym_cnt), 100);
        check("t1_ovf", 32'(ovf), 0);
        check("t1_rv_pulses", 32'(rv_cnt - rv_base), 1);
        check("t1_busy_idle", 32'(busy), 0);
        check("t1_sat_sym", 32'(sym_cnt_s), 15);
        check("t1_sat_ovf", 32'(ovf_s), 1);

        // Compare one symbol early on random data
        dsel = 3'd1;
        idle(2);
        pulse_start();
        repeat (3) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        e0 = 0; e1 = 0; model_on = 1;
        for (int i = 0; i < 99; i++) begin
            send(1'b0, 4'h0);
            if (i == 10 || i == 41 || i == 77)
                check("t2_sym_err", 32'(sym_err), {30'd0, |last_m[3:2], |last_m[1:0]});
        end
        send(1'b1, 4'h0);
        model_on = 0;
        idle(2);
        check("t2_err0", 32'(err_cnt[21:0]), 32'(e0));
        check("t2_err1", 32'(err_cnt[43:22]), 32'(e1));
        check("t2_err0_many", 32'(err_cnt[21:0] > 22'd40), 1);
        check("t2_sym_cnt", 32'(sym_cnt), 100);

        // Channel 1 corrupted for 10 symbols of a 50-symbol window
        dsel = 3'd2;
        idle(2);
        pulse_start();
        repeat (3) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        for (int i = 0; i < 49; i++)
            send(1'b0, (i >= 10 && i < 20) ? 4'b1100 : 4'b0000);
        send(1'b1, 4'h0);
        idle(2);
        check("t3_err0", 32'(err_cnt[21:0]), 0);
        check("t3_err1", 32'(err_cnt[43:22]), 10);
        check("t3_sym_cnt", 32'(sym_cnt), 50);

        // All-error window of 20 symbols saturates the 4-bit instance
        pulse_start();
        send(1'b1, 4'h0);
        repeat (19) send(1'b0, 4'hF);
        send(1'b1, 4'hF);
        idle(2);
        check("t4_sat_err0", 32'(err_cnt_s[3:0]), 15);
        check("t4_sat_err1", 32'(err_cnt_s[7:4]), 15);
        check("t4_sat_sym", 32'(sym_cnt_s), 15);
        check("t4_sat_ovf", 32'(ovf_s), 1);
        check("t4_wide_err1", 32'(err_cnt[43:22]), 20);
        check("t4_wide_sym", 32'(sym_cnt), 20);
        pulse_start();
        send(1'b1, 4'h0);
        repeat (9) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(2);
        check("t4_clean_err0", 32'(err_cnt_s[3:0]), 0);
        check("t4_clean_sym", 32'(sym_cnt_s), 10);
        check("t4_clean_ovf", 32'(ovf_s), 0);

        // Continuous mode, 64-symbol windows, then a mid-window delay change
        cont = 1'b1;
        idle(2);
        send(1'b1, 4'h0);
        rv_base = rv_cnt;
        for (int w = 0; w < 3; w++) begin
            repeat (63) send(1'b0, 4'h0);
            send(1'b1, 4'h0);
            idle(1);
            check("t5_sym_cnt", 32'(sym_cnt), 64);
        end
        check("t5_rv_pulses", 32'(rv_cnt - rv_base), 3);
        repeat (30) send(1'b0, 4'h0);
        @(negedge clk); dsel = 3'd3; slc_dly = 3'd3;
        repeat (33) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(1);
        check("t5_discard_rv", 32'(rv_cnt - rv_base), 3);
        check("t5_discard_busy", 32'(busy), 1);
        repeat (63) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(1);
        check("t5_rearm_rv", 32'(rv_cnt - rv_base), 4);
        check("t5_rearm_sym", 32'(sym_cnt), 64);
        repeat (20) send(1'b0, 4'h0);
        cont = 1'b0;
        repeat (43) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(2);
        check("t5_last_rv", 32'(rv_cnt - rv_base), 5);
        check("t5_last_sym", 32'(sym_cnt), 64);
        check("t5_idle", 32'(busy), 0);

        // Asynchronous reset in the middle of a window
        pulse_start();
        send(1'b1, 4'h0);
        repeat (10) send(1'b0, 4'h1);
        #3 rst_n = 1'b0;
        #1;
        check("t6_err_cnt", 32'(err_cnt), 0);
        check("t6_sym_cnt", 32'(sym_cnt), 0);
        check("t6_flags", {ovf, rv, busy, sym_err}, 0);
        clear_hist();
        @(negedge clk); rst_n = 1'b1;
        idle(3);
        pulse_start();
        rv_base = rv_cnt;
        send(1'b1, 4'h0);
        repeat (5) send(1'b0, 4'h0);
        send(1'b1, 4'h0);
        idle(2);
        check("t6_restart_sym", 32'(sym_cnt), 6);
        check("t6_restart_rv", 32'(rv_cnt - rv_base), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
